// File: rtl/core_inst_sequencer.sv
// core_inst_sequencer: autonomous instruction generator for the conv core.
// One start pulse walks every kernel position (weights xmem->L0->PE,
// activations xmem->L0, execute, OFIFO->pmem), then accumulates each output
// pixel from pmem in kij order and applies relu. All outputs are registered;
// the instruction word is decoded from the next state so it lines up with it.
module core_inst_sequencer #(
  parameter int            ROW    = 8,
  parameter int            COL    = 8,
  parameter int            IN_W   = 6,
  parameter int            K_W    = 3,
  parameter int            GAP    = 10,
  parameter int            AW     = 11,
  parameter logic [AW-1:0] W_BASE = 11'h400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ecc_error,
  input  logic        w_ready,
  output logic [34:0] inst,
  output logic [3:0]  cur_kij,
  output logic        out_valid,
  output logic [7:0]  out_idx,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int LEN_NIJ = IN_W * IN_W;
  localparam int LEN_KIJ = K_W * K_W;
  localparam int O_W     = IN_W - K_W + 1;
  localparam int CW      = 16;

  localparam logic [34:0]   RST_INST = 35'h1_800C_0000;
  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] ROW_LAST = CW'(ROW - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COL - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP - 1);
  localparam logic [CW-1:0] NIJ_LAST = CW'(LEN_NIJ - 1);
  localparam logic [3:0]    KIJ_LAST = 4'(LEN_KIJ - 1);
  localparam logic [7:0]    J_END    = 8'(LEN_KIJ);
  localparam logic [7:0]    KW_LAST  = 8'(K_W - 1);
  localparam logic [7:0]    OW_LAST  = 8'(O_W - 1);

  // The pmem partial-sum layout must fit without address wrap.
  if (LEN_KIJ * LEN_NIJ > (2 ** AW)) begin : g_addr_range
    $error("core_inst_sequencer: K_W*K_W*IN_W*IN_W exceeds the 2^AW address space");
  end

  typedef enum logic [3:0] {
    S_IDLE, S_W_WAIT, S_W_L0, S_W_LOAD, S_GAP1, S_X_L0, S_EXEC,
    S_GAP2, S_OF_RD, S_ACC, S_RELU, S_DONE, S_ERR
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    kij_q, kij_d;
  logic [CW-1:0] t_q, t_d;
  logic          ph_q, ph_d;
  logic [7:0]    j_q, j_d, kr_q, kr_d, kc_q, kc_d, orow_q, orow_d, ocol_q, ocol_d;

  logic [34:0]   inst_q, inst_d;
  logic [3:0]    cur_kij_q;
  logic          out_valid_q, busy_q, done_q, err_q;
  logic [7:0]    out_idx_q;

  logic          relu_s, acc_s, cen_p_s, wen_p_s, cen_x_s, wen_x_s;
  logic [AW-1:0] a_p_s, a_x_s;
  logic          ofifo_rd_s, l0_rd_s, l0_wr_s, execute_s, load_s;

  function automatic logic is_busy(input state_t s);
    case (s)
      S_IDLE, S_DONE, S_ERR: is_busy = 1'b0;
      default:               is_busy = 1'b1;
    endcase
  endfunction

  // Next state and step counters; an ECC error in any busy state aborts.
  always_comb begin
    state_d = state_q;
    kij_d   = kij_q;
    t_d     = t_q;
    ph_d    = ph_q;
    j_d     = j_q;
    kr_d    = kr_q;
    kc_d    = kc_q;
    orow_d  = orow_q;
    ocol_d  = ocol_q;
    if (is_busy(state_q) && ecc_error) begin
      state_d = S_ERR;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state_d = S_W_WAIT;
            kij_d   = 4'd0;
            t_d     = '0;
            ph_d    = 1'b0;
          end else begin
            state_d = state_q;
          end
        end
        S_W_WAIT: begin
          if (w_ready) begin
            state_d = S_W_L0;
            t_d     = '0;
            ph_d    = 1'b0;
          end else begin
            state_d = state_q;
          end
        end
        S_W_L0, S_X_L0, S_OF_RD: begin
          // Two cycles per row: issue the memory access, then consume it.
          if (!ph_q) begin
            ph_d = 1'b1;
          end else begin
            ph_d = 1'b0;
            if ((state_q == S_W_L0 && t_q == ROW_LAST) ||
                (state_q != S_W_L0 && t_q == NIJ_LAST)) begin
              t_d = '0;
              if (state_q == S_W_L0) begin
                state_d = S_W_LOAD;
              end else if (state_q == S_X_L0) begin
                state_d = S_EXEC;
              end else if (kij_q == KIJ_LAST) begin
                state_d = S_ACC;
                j_d     = 8'd0;
                kr_d    = 8'd0;
                kc_d    = 8'd0;
                orow_d  = 8'd0;
                ocol_d  = 8'd0;
              end else begin
                state_d = S_W_WAIT;
                kij_d   = kij_q + 4'd1;
              end
            end else begin
              t_d = t_q + ONE;
            end
          end
        end
        S_W_LOAD, S_GAP1, S_EXEC, S_GAP2: begin
          if ((state_q == S_W_LOAD && t_q == COL_LAST) ||
              (state_q == S_EXEC   && t_q == NIJ_LAST) ||
              ((state_q == S_GAP1 || state_q == S_GAP2) && t_q == GAP_LAST)) begin
            t_d  = '0;
            ph_d = 1'b0;
            case (state_q)
              S_W_LOAD: state_d = S_GAP1;
              S_GAP1:   state_d = S_X_L0;
              S_EXEC:   state_d = S_GAP2;
              default:  state_d = S_OF_RD;
            endcase
          end else begin
            t_d = t_q + ONE;
          end
        end
        S_ACC: begin
          if (j_q == J_END) begin
            state_d = S_RELU;
          end else begin
            j_d = j_q + 8'd1;
            if (kc_q == KW_LAST) begin
              kc_d = 8'd0;
              kr_d = kr_q + 8'd1;
            end else begin
              kc_d = kc_q + 8'd1;
            end
          end
        end
        S_RELU: begin
          j_d  = 8'd0;
          kr_d = 8'd0;
          kc_d = 8'd0;
          if (ocol_q == OW_LAST) begin
            ocol_d = 8'd0;
            if (orow_q == OW_LAST) begin
              state_d = S_DONE;
            end else begin
              orow_d  = orow_q + 8'd1;
              state_d = S_ACC;
            end
          end else begin
            ocol_d  = ocol_q + 8'd1;
            state_d = S_ACC;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Instruction word for the step the FSM is about to enter.
  always_comb begin
    relu_s = 1'b0; acc_s = 1'b0; cen_p_s = 1'b1; wen_p_s = 1'b1; a_p_s = '0;
    cen_x_s = 1'b1; wen_x_s = 1'b1; a_x_s = '0;
    ofifo_rd_s = 1'b0; l0_rd_s = 1'b0; l0_wr_s = 1'b0; execute_s = 1'b0; load_s = 1'b0;
    case (state_d)
      S_W_L0, S_X_L0: begin
        if (!ph_d) begin
          cen_x_s = 1'b0;
          a_x_s   = (state_d == S_W_L0) ? W_BASE + AW'(t_d) : AW'(t_d);
        end else begin
          l0_wr_s = 1'b1;
        end
      end
      S_W_LOAD: begin
        l0_rd_s = 1'b1;
        load_s  = 1'b1;
      end
      S_EXEC: begin
        l0_rd_s   = 1'b1;
        execute_s = 1'b1;
      end
      S_OF_RD: begin
        if (!ph_d) begin
          ofifo_rd_s = 1'b1;
          cen_p_s    = 1'b0;
          wen_p_s    = 1'b0;
          a_p_s      = AW'(kij_d) * AW'(LEN_NIJ) + AW'(t_d);
        end else begin
          ofifo_rd_s = 1'b0;
        end
      end
      S_ACC: begin
        acc_s = (j_d != 8'd0);
        if (j_d < J_END) begin
          cen_p_s = 1'b0;
          a_p_s   = AW'(j_d) * AW'(LEN_NIJ) + (AW'(orow_d) + AW'(kr_d)) * AW'(IN_W)
                    + AW'(ocol_d) + AW'(kc_d);
        end else begin
          cen_p_s = 1'b1;
        end
      end
      S_RELU:  relu_s = 1'b1;
      default: relu_s = 1'b0;
    endcase
    inst_d = {relu_s, acc_s, cen_p_s, wen_p_s, a_p_s, cen_x_s, wen_x_s, a_x_s,
              ofifo_rd_s, 1'b0, 1'b0, l0_rd_s, l0_wr_s, execute_s, load_s};
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      kij_q       <= 4'd0;
      t_q         <= '0;
      ph_q        <= 1'b0;
      j_q         <= 8'd0;
      kr_q        <= 8'd0;
      kc_q        <= 8'd0;
      orow_q      <= 8'd0;
      ocol_q      <= 8'd0;
      inst_q      <= RST_INST;
      cur_kij_q   <= 4'd0;
      out_valid_q <= 1'b0;
      out_idx_q   <= 8'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      kij_q       <= kij_d;
      t_q         <= t_d;
      ph_q        <= ph_d;
      j_q         <= j_d;
      kr_q        <= kr_d;
      kc_q        <= kc_d;
      orow_q      <= orow_d;
      ocol_q      <= ocol_d;
      inst_q      <= (state_d == S_ERR) ? RST_INST : inst_d;
      cur_kij_q   <= kij_d;
      out_valid_q <= (state_q == S_RELU) && (state_d != S_ERR);
      if (state_q == S_RELU) begin
        out_idx_q <= orow_q * 8'(O_W) + ocol_q;
      end
      busy_q      <= is_busy(state_d);
      done_q      <= (state_d == S_DONE);
      err_q       <= (state_d == S_ERR);
    end
  end

  assign inst      = inst_q;
  assign cur_kij   = cur_kij_q;
  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
